// File: rtl/row_ring_buffer.sv
// row_ring_buffer: ring of line buffers for raster pixel streams.
// Vertical column reads with bottom- and right-edge replication.
module row_ring_buffer #(
  parameter int PIX_W     = 8,
  parameter int NUM_LINES = 4,
  parameter int COL_AW    = 10,
  parameter int ROW_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  input  logic [COL_AW:0]            cfg_cols,
  input  logic [ROW_W-1:0]           cfg_rows,
  output logic                       cfg_error,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_pixel,
  input  logic                       rd_en,
  input  logic [COL_AW-1:0]          rd_col,
  output logic [NUM_LINES*PIX_W-1:0] rd_pixels,
  output logic                       rd_valid,
  output logic [ROW_W-1:0]           rd_row_base,
  output logic [4:0]                 lines_ready,
  input  logic                       row_release,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int LW = (NUM_LINES > 1) ?
    $clog2(NUM_LINES) : 1;
  localparam int DEPTH = 1 << COL_AW;
  localparam logic [COL_AW:0] MAX_COLS =
    (COL_AW+1)'(DEPTH);
  localparam logic [LW-1:0] LAST_LINE =
    LW'(NUM_LINES - 1);
  localparam logic [LW:0] NL = (LW+1)'(NUM_LINES);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [COL_AW:0]    cols_q;
  logic [COL_AW:0]    col_last;
  logic [ROW_W-1:0]   rows_q;
  logic [ROW_W-1:0]   wr_row;
  logic [ROW_W-1:0]   base;
  logic [COL_AW-1:0]  wr_col;
  logic [COL_AW-1:0]  rd_addr;
  logic [LW-1:0]      wr_line;
  logic [LW-1:0]      oldest;
  logic [LW-1:0]      old_s;
  logic [4:0]         lr;
  logic [4:0]         lr_s;
  logic [4:0]         lane;
  logic [LW:0]        sum;
  logic               cfg_ok;
  logic               cfg_take;
  logic               cfg_bad;
  logic               acc;
  logic               line_done;
  logic               rel;
  logic               last_rel;
  logic               rd_fire;
  logic [PIX_W-1:0]   rdata [NUM_LINES];

  function automatic logic [LW-1:0] next_line(
    input logic [LW-1:0] v
  );
    return (v == LAST_LINE) ? '0 : v + LW'(1);
  endfunction

  assign cfg_ok = (cfg_cols != '0) &&
                  (cfg_cols <= MAX_COLS) &&
                  (cfg_rows != '0);
  assign cfg_take = (state_q == IDLE) &&
                    cfg_valid && cfg_ok;
  assign cfg_bad = (state_q == IDLE) &&
                   cfg_valid && !cfg_ok;

  assign in_ready = (state_q == ACTIVE) &&
                    (lr < 5'(NUM_LINES)) &&
                    (wr_row < rows_q);
  assign acc = in_valid && in_ready;
  assign col_last = cols_q - (COL_AW+1)'(1);
  assign line_done = acc &&
                     ({1'b0, wr_col} == col_last);
  assign rel = (state_q == ACTIVE) &&
               row_release && (lr != '0);
  assign last_rel = rel &&
                    (base == rows_q - ROW_W'(1));
  assign rd_fire = (state_q == ACTIVE) &&
                   rd_en && (lr != '0);
  assign rd_addr = ({1'b0, rd_col} >= cols_q) ?
                   col_last[COL_AW-1:0] : rd_col;

  assign busy        = (state_q == ACTIVE);
  assign lines_ready = lr;
  assign rd_row_base = base;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state: start on good config, stop on last release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (cfg_take) state_d = ACTIVE;
      ACTIVE: if (last_rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // write/release pointers, counters and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_q     <= '0;
      rows_q     <= '0;
      wr_col     <= '0;
      wr_line    <= '0;
      wr_row     <= '0;
      oldest     <= '0;
      base       <= '0;
      lr         <= '0;
      cfg_error  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cfg_error  <= cfg_bad;
      frame_done <= last_rel;
      if (cfg_take) begin
        cols_q  <= cfg_cols;
        rows_q  <= cfg_rows;
        wr_col  <= '0;
        wr_line <= '0;
        wr_row  <= '0;
        oldest  <= '0;
        base    <= '0;
        lr      <= '0;
      end else begin
        if (acc) begin
          if (line_done) begin
            wr_col  <= '0;
            wr_line <= next_line(wr_line);
            wr_row  <= wr_row + ROW_W'(1);
          end else begin
            wr_col  <= wr_col + COL_AW'(1);
          end
        end
        if (rel) begin
          oldest <= next_line(oldest);
          base   <= base + ROW_W'(1);
        end
        if (line_done && !rel)
          lr <= lr + 5'd1;
        else if (rel && !line_done)
          lr <= lr - 5'd1;
      end
    end
  end

  // read-side snapshot of ring state at the request cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      lr_s     <= '0;
      old_s    <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        lr_s  <= lr;
        old_s <= oldest;
      end
    end
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] q;

    // write port: only the line currently being filled
    always_ff @(posedge clk) begin
      if (acc && (wr_line == LW'(g)))
        mem[wr_col] <= in_pixel;
    end

    // synchronous read port
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       q <= '0;
      else if (rd_fire) q <= mem[rd_addr];
    end

    assign rdata[g] = q;
  end

  // lane steering with bottom-edge replication
  always_comb begin
    rd_pixels = '0;
    lane = '0;
    sum = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      lane = (5'(k) < lr_s) ? 5'(k) : lr_s - 5'd1;
      sum = {1'b0, old_s} + (LW+1)'(lane);
      if (sum >= NL) sum = sum - NL;
      if (lr_s != '0)
        rd_pixels[k*PIX_W +: PIX_W] =
          rdata[sum[LW-1:0]];
    end
  end

endmodule

// File: doc/row_ring_buffer.md
ROW_RING_BUFFER -- requirements
Module: row_ring_buffer

Interface
REQ-001 Parameter: PIX_W, 8, pixel width in bits.
REQ-002 Parameter: NUM_LINES, 4, number of line buffers (2..16).
REQ-003 Parameter: COL_AW, 10, column address width; max image width 2^COL_AW.
REQ-004 Parameter: ROW_W, 16, row counter width.
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 cfg_valid  in  1  one-cycle strobe latching cfg_cols/cfg_rows.
REQ-008 cfg_cols  in  COL_AW+1  image width in pixels.
REQ-009 cfg_rows  in  ROW_W  image height in rows.
REQ-010 cfg_error  out  1  one-cycle pulse: rejected configuration.
REQ-011 in_valid  in  1  input pixel valid.
REQ-012 in_ready  out  1  input pixel accepted when in_valid && in_ready.
REQ-013 in_pixel  in  PIX_W  input pixel, raster order.
REQ-014 rd_en  in  1  read request for column rd_col.
REQ-015 rd_col  in  COL_AW  column to read.
REQ-016 rd_pixels  out  NUM_LINES*PIX_W  vertical pixel column; lane 0 (LSBs) = oldest row.
REQ-017 rd_valid  out  1  rd_pixels valid.
REQ-018 rd_row_base  out  ROW_W  image row index held in lane 0.
REQ-019 lines_ready  out  5  count of complete, unreleased lines.
REQ-020 row_release  in  1  consumer frees oldest complete line.
REQ-021 busy  out  1  high outside IDLE.
REQ-022 frame_done  out  1  one-cycle pulse: last row released.

Function
REQ-023 States IDLE, ACTIVE; storage = NUM_LINES arrays of 2^COL_AW x PIX_W, one write and one synchronous read port each, no vendor IP.
REQ-024 IDLE: cfg_valid with 1 <= cfg_cols <= 2^COL_AW and cfg_rows >= 1 latches both, clears all counters/pointers, -> ACTIVE next cycle; otherwise cfg_error pulses, stay IDLE.
REQ-025 cfg_valid in ACTIVE is ignored (no error, no relatch).
REQ-026 in_ready = ACTIVE && lines_ready < NUM_LINES && wr_row < cfg_rows (combinational from registers).
REQ-027 Accepted pixel written at (wr_line, wr_col); wr_col increments; at wr_col == cols-1 it wraps to 0, wr_line advances mod NUM_LINES, wr_row and lines_ready increment.
REQ-028 row_release with lines_ready == 0 is ignored; otherwise lines_ready decrements, oldest pointer advances mod NUM_LINES, rd_row_base increments.
REQ-029 Line completion and row_release in the same cycle: lines_ready unchanged, both pointers advance.
REQ-030 Partially written line is never visible to reads.
REQ-031 Read latency 1 cycle: rd_en at cycle t with lines_ready > 0 -> rd_valid and rd_pixels at t+1; rd_en with lines_ready == 0 or in IDLE -> rd_valid 0.
REQ-032 Lane k maps to line (oldest+k) mod NUM_LINES for k < lines_ready; lanes k >= lines_ready replicate lane lines_ready-1 (bottom-edge replication).
REQ-033 rd_col >= cols is clamped to cols-1 (right-edge replication).
REQ-034 Read data reflect lines_ready/oldest sampled at the rd_en cycle; a release in the same cycle does not alter that read.
REQ-035 When the release of row cfg_rows-1 occurs: frame_done pulses next cycle, state -> IDLE, in_ready 0.
REQ-036 Write and read of the same line never collide: writes target only non-complete lines.

Reset
REQ-037 reset low asynchronously forces IDLE; in_ready, rd_valid, cfg_error, frame_done, busy = 0; lines_ready, rd_row_base, rd_pixels = 0; all pointers/counters = 0.
REQ-038 Reset mid-frame discards all buffered lines; memory contents need not be cleared; first cycle after release is IDLE.

Verification
REQ-039 cols=4, rows=3, NUM_LINES=4, pixels 1..12 streamed, no release -> lines_ready 3, in_ready 0; rd_col=2 -> rd_pixels lanes {3,7,11,11}, rd_row_base 0.
REQ-040 cols=4, rows=8, consumer never releases -> in_ready drops after 16th pixel; one row_release -> in_ready rises next cycle, rd_row_base 1, 17th pixel lands in physical line 0.
REQ-041 Release on the exact cycle a line completes (lines_ready=2) -> lines_ready stays 2, lane 0 is next row.
REQ-042 cfg_cols=0, then cfg_cols=2^COL_AW+1 -> cfg_error pulse each, busy stays 0; cfg_cols=1024, rows=1 accepted, rd_col=1023 returns last pixel.
REQ-043 rows=2 fully streamed and both released -> frame_done single pulse, busy 0; rd_en afterwards -> rd_valid 0.
REQ-044 reset asserted after 6 of 16 pixels -> all outputs zero immediately; new config restarts at rd_row_base 0, lines_ready 0.
